// File: rtl/hazard_sweep_ctrl.sv
// ============================================================================
// hazard_sweep_ctrl : sweeps a combinational DUT through every ordered pair of
//                     distinct input vectors and classifies output glitches.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_sweep_ctrl #(
  parameter int N_IN  = 3,
  parameter int HOLD  = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N_IN-1:0]  dut_in,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             hz_valid,
  output logic [N_IN-1:0]  hz_from,
  output logic [N_IN-1:0]  hz_to,
  output logic [1:0]       hz_kind,
  output logic [CNT_W-1:0] hz_count
);

  localparam int              HC_W      = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD - 1);
  localparam logic [N_IN-1:0] IDX_MAX   = '1;
  localparam logic [N_IN-1:0] IDX_ONE   = N_IN'(1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_HOLD_FROM = 3'd1;
  localparam logic [2:0] S_HOLD_TO   = 3'd2;
  localparam logic [2:0] S_CHECK     = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  localparam logic [1:0] KIND_S0  = 2'b00;
  localparam logic [1:0] KIND_S1  = 2'b01;
  localparam logic [1:0] KIND_DYN = 2'b10;

  logic [2:0]       state_q,    state_d;
  logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [N_IN-1:0]  i_q,        i_d;
  logic [N_IN-1:0]  j_q,        j_d;
  logic [N_IN-1:0]  dut_in_q,   dut_in_d;
  logic             out_q,      out_d;
  logic             out_prev_q, out_prev_d;
  logic             v0_q,       v0_d;
  logic             v1_q,       v1_d;
  logic [1:0]       tog_q,      tog_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic             hz_valid_q, hz_valid_d;
  logic [N_IN-1:0]  hz_from_q,  hz_from_d;
  logic [N_IN-1:0]  hz_to_q,    hz_to_d;
  logic [1:0]       hz_kind_q,  hz_kind_d;
  logic [CNT_W-1:0] hz_count_q, hz_count_d;

  logic [N_IN-1:0] to_vec;
  logic            hold_last;
  logic [1:0]      tog_inc;
  logic            hazard;
  logic [1:0]      kind;

  assign to_vec    = j_q + i_q;
  assign hold_last = (hold_cnt_q == HOLD_LAST);
  assign tog_inc   = ((out_q != out_prev_q) && (tog_q != 2'd3)) ? tog_q + 2'd1 : tog_q;

  // Classified on the last HOLD_TO cycle with that cycle's sample (the value
  // v1 latches) so the registered pulse lands exactly on the CHECK cycle.
  assign hazard = (v0_q == out_q) ? (tog_inc != 2'd0) : (tog_inc > 2'd1);
  assign kind   = (v0_q != out_q) ? KIND_DYN : (out_q ? KIND_S1 : KIND_S0);

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    i_d        = i_q;
    j_d        = j_q;
    dut_in_d   = dut_in_q;
    out_d      = dut_out;
    out_prev_d = out_q;
    v0_d       = v0_q;
    v1_d       = v1_q;
    tog_d      = tog_q;
    busy_d     = busy_q;
    done_d     = done_q;
    hz_valid_d = 1'b0;
    hz_from_d  = hz_from_q;
    hz_to_d    = hz_to_q;
    hz_kind_d  = hz_kind_q;
    hz_count_d = hz_count_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          i_d        = IDX_ONE;
          j_d        = '0;
          hz_count_d = '0;
          done_d     = 1'b0;
          busy_d     = 1'b1;
          tog_d      = 2'd0;
          hold_cnt_d = '0;
          dut_in_d   = '0;
          state_d    = S_HOLD_FROM;
        end
      end

      S_HOLD_FROM: begin
        hold_cnt_d = hold_cnt_q + 1'b1;
        if (hold_last) begin
          v0_d       = out_q;
          dut_in_d   = to_vec;
          hold_cnt_d = '0;
          state_d    = S_HOLD_TO;
        end
      end

      S_HOLD_TO: begin
        tog_d      = tog_inc;
        hold_cnt_d = hold_cnt_q + 1'b1;
        if (hold_last) begin
          v1_d       = out_q;
          hold_cnt_d = '0;
          state_d    = S_CHECK;
          if (hazard) begin
            hz_valid_d = 1'b1;
            hz_from_d  = j_q;
            hz_to_d    = to_vec;
            hz_kind_d  = kind;
            if (hz_count_q != {CNT_W{1'b1}}) begin
              hz_count_d = hz_count_q + 1'b1;
            end
          end
        end
      end

      S_CHECK: begin
        tog_d   = 2'd0;
        state_d = S_HOLD_FROM;
        if (j_q == IDX_MAX) begin
          j_d = '0;
          if (i_q == IDX_MAX) begin
            // dut_in keeps the final 'to' vector while results are held
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            i_d      = i_q + 1'b1;
            dut_in_d = '0;
          end
        end else begin
          j_d      = j_q + 1'b1;
          dut_in_d = j_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hold_cnt_q <= '0;
      i_q        <= '0;
      j_q        <= '0;
      dut_in_q   <= '0;
      out_q      <= 1'b0;
      out_prev_q <= 1'b0;
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
      tog_q      <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hz_valid_q <= 1'b0;
      hz_from_q  <= '0;
      hz_to_q    <= '0;
      hz_kind_q  <= KIND_S0;
      hz_count_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      i_q        <= i_d;
      j_q        <= j_d;
      dut_in_q   <= dut_in_d;
      out_q      <= out_d;
      out_prev_q <= out_prev_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      tog_q      <= tog_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hz_valid_q <= hz_valid_d;
      hz_from_q  <= hz_from_d;
      hz_to_q    <= hz_to_d;
      hz_kind_q  <= hz_kind_d;
      hz_count_q <= hz_count_d;
    end
  end

  assign dut_in   = dut_in_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign hz_valid = hz_valid_q;
  assign hz_from  = hz_from_q;
  assign hz_to    = hz_to_q;
  assign hz_kind  = hz_kind_q;
  assign hz_count = hz_count_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_sweep_ctrl.sv
// ============================================================================
// tb_hazard_sweep_ctrl : drives hazard_sweep_ctrl with behavioural glitchy DUT
//                        models and checks every cycle against a pair model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hazard_sweep_ctrl;

  localparam int NP    = 56;
  localparam int PL    = 17;
  localparam int SWEEP = NP * PL;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       dut_out = 1'b0;
  logic [2:0] dut_in, hz_from, hz_to;
  logic       busy, done, hz_valid;
  logic [1:0] hz_kind;
  logic [7:0] hz_count;

  logic [2:0] dut_in2, hz_from2, hz_to2;
  logic       busy2, done2, hz_valid2;
  logic [1:0] hz_kind2;
  logic [1:0] hz_count2;

  int checks = 0;
  int errors = 0;
  int mode = 0;

  // model of the sweep, indexed by pair number p = (i-1)*8 + j
  int         kinds[NP];
  bit         run = 1'b0;
  int         k = 0;
  logic [2:0] base_from = '0, base_to = '0;
  logic [1:0] base_kind = '0;

  logic [2:0] cur_v = '0, prv_v = '0;
  int         age = 15;

  hazard_sweep_ctrl #(.N_IN(3), .HOLD(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .hz_valid(hz_valid), .hz_from(hz_from),
    .hz_to(hz_to), .hz_kind(hz_kind), .hz_count(hz_count)
  );

  hazard_sweep_ctrl #(.N_IN(3), .HOLD(8), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .start(start), .dut_in(dut_in2), .dut_out(dut_out),
    .busy(busy2), .done(done2), .hz_valid(hz_valid2), .hz_from(hz_from2),
    .hz_to(hz_to2), .hz_kind(hz_kind2), .hz_count(hz_count2)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] pf(int p);
    return 3'(p % 8);
  endfunction

  function automatic logic [2:0] pt(int p);
    return 3'((p % 8 + p / 8 + 1) % 8);
  endfunction

  // settled output; bits are ordered a=[2], b=[1], c=[0]
  function automatic logic base_out(int m, logic [2:0] x);
    return (m == 4) ? 1'b0 : (x[2] & x[0]);
  endfunction

  // output 'a' cycles after the inputs moved from f to t
  function automatic logic wave(int m, logic [2:0] f, logic [2:0] t, int a);
    if (a >= 7) return base_out(m, t);
    case (m)
      1: if (!f[0] && t[0] && t[1] && !t[2] && a < 2) return 1'b1;
      2: if (f == 3'd7 && t == 3'd5 && a == 0) return 1'b0;
      3: if (f == 3'd1 && t == 3'd5) return (a == 1) ? 1'b0 : 1'b1;
      4: if (a == 0) return 1'b1;
      default: ;
    endcase
    return base_out(m, t);
  endfunction

  // 0 static-0, 1 static-1, 2 dynamic, 3 no hazard
  function automatic int pair_kind(int m, logic [2:0] f, logic [2:0] t);
    logic v0, v1, prev, w;
    int   tog;
    v0 = base_out(m, f);
    v1 = base_out(m, t);
    prev = v0;
    tog = 0;
    for (int a = 0; a < 7; a++) begin
      w = wave(m, f, t, a);
      if (w != prev) tog++;
      prev = w;
    end
    if (v0 == v1 && tog > 0) return v0 ? 1 : 0;
    if (v0 != v1 && tog > 1) return 2;
    return 3;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // circuit-under-test model
  always @(posedge clk) begin
    #1;
    if (dut_in !== cur_v) begin
      prv_v = cur_v;
      cur_v = dut_in;
      age = 0;
    end else if (age < 15) begin
      age++;
    end
    dut_out = wave(mode, prv_v, cur_v, age);
  end

  // sweep position tracker
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      run = 1'b0;
      k = 0;
      base_from = '0;
      base_to = '0;
      base_kind = '0;
    end else if (start && (!run || k >= SWEEP)) begin
      if (run) begin
        for (int q = NP - 1; q >= 0; q--) begin
          if (kinds[q] != 3) begin
            base_from = pf(q);
            base_to = pt(q);
            base_kind = 2'(kinds[q]);
            break;
          end
        end
      end
      for (int p = 0; p < NP; p++) kinds[p] = pair_kind(mode, pf(p), pt(p));
      run = 1'b1;
      k = 0;
    end else if (run && k < SWEEP) begin
      k++;
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    int e_din, e_busy, e_done, e_val, e_from, e_to, e_kind, n, last, lim, p, ph;
    e_din = 0; e_busy = 0; e_done = 0; e_val = 0; n = 0; last = -1; lim = -1;
    if (run) begin
      if (k >= SWEEP) begin
        e_din = int'(pt(NP - 1));
        e_done = 1;
        lim = NP - 1;
      end else begin
        p = k / PL;
        ph = k % PL;
        e_din = (ph < 8) ? int'(pf(p)) : int'(pt(p));
        e_busy = 1;
        lim = (ph == PL - 1) ? p : p - 1;
        e_val = (ph == PL - 1 && kinds[p] != 3) ? 1 : 0;
      end
      for (int q = 0; q <= lim; q++) begin
        if (kinds[q] != 3) begin
          n++;
          last = q;
        end
      end
    end
    e_from = (last >= 0) ? int'(pf(last)) : int'(base_from);
    e_to   = (last >= 0) ? int'(pt(last)) : int'(base_to);
    e_kind = (last >= 0) ? kinds[last]    : int'(base_kind);
    chk("dut_in", dut_in, e_din);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("hz_valid", hz_valid, e_val);
    chk("hz_from", hz_from, e_from);
    chk("hz_to", hz_to, e_to);
    chk("hz_kind", hz_kind, e_kind);
    chk("hz_count", hz_count, n);
    chk("hz_count_sat", hz_count2, (n > 3) ? 3 : n);
  end

  task automatic run_sweep(input int m, input bit poke, output int cyc, output int npulse,
                           output int f_from, output int f_to, output int f_kind);
    @(negedge clk);
    mode = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    npulse = 0;
    f_from = -1; f_to = -1; f_kind = -1;
    while (!done && cyc < 1100) begin
      if (hz_valid) begin
        npulse++;
        if (f_from < 0) begin
          f_from = int'(hz_from); f_to = int'(hz_to); f_kind = int'(hz_kind);
        end
      end
      start = (poke && cyc == 400);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL sweep_timeout: done never rose within %0d cycles", cyc);
    end
  endtask

  initial begin
    int cyc, np, ff, ft, fk;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dut_in", dut_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", hz_count, 0);
    rst = 1'b0;

    run_sweep(0, 1'b0, cyc, np, ff, ft, fk);
    chk("m0_cycles", cyc, 952);
    chk("m0_count", hz_count, 0);
    chk("m0_pulses", np, 0);
    chk("m0_busy", busy, 0);

    run_sweep(1, 1'b1, cyc, np, ff, ft, fk);
    chk("m1_cycles", cyc, 952);
    chk("m1_count", hz_count, 4);
    chk("m1_pulses", np, 4);
    chk("m1_first_from", ff, 2);
    chk("m1_first_to", ft, 3);
    chk("m1_first_kind", fk, 0);

    run_sweep(2, 1'b0, cyc, np, ff, ft, fk);
    chk("m2_count", hz_count, 1);
    chk("m2_from", hz_from, 7);
    chk("m2_to", hz_to, 5);
    chk("m2_kind", hz_kind, 1);

    run_sweep(3, 1'b0, cyc, np, ff, ft, fk);
    chk("m3_count", hz_count, 1);
    chk("m3_from", hz_from, 1);
    chk("m3_to", hz_to, 5);
    chk("m3_kind", hz_kind, 2);

    run_sweep(4, 1'b0, cyc, np, ff, ft, fk);
    chk("m4_count", hz_count, 56);
    chk("m4_sat_count", hz_count2, 3);
    chk("m4_last_din", dut_in, 6);

    @(negedge clk);
    mode = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (300) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_dut_in", dut_in, 0);
    chk("arst_busy", busy, 0);
    chk("arst_valid", hz_valid, 0);
    chk("arst_count", hz_count, 0);
    chk("arst_from", hz_from, 0);
    chk("arst_to", hz_to, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_sweep(0, 1'b0, cyc, np, ff, ft, fk);
    chk("post_rst_cycles", cyc, 952);
    chk("post_rst_count", hz_count, 0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
